// File: rtl/vpifo_op_scheduler.sv
// vpifo_op_scheduler: round-robin sharing of one PIFO push/pop issue slot
// among TREE_NUM virtual trees. Keeps per-tree occupancy counters so that
// full trees are never pushed and empty trees are never popped. Enforces a
// same-tree reissue gap, and routes returned pop data back to the tree that
// issued the pop.
module vpifo_op_scheduler #(
  parameter int PTW      = 16,
  parameter int TREE_NUM = 4,
  parameter int TREE_CAP = 72,
  parameter int GAP      = 2,
  parameter int POP_LAT  = 3,
  localparam int TID     = $clog2(TREE_NUM),
  localparam int CW      = $clog2(TREE_CAP + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic [TREE_NUM-1:0]     i_req_valid,
  input  logic [TREE_NUM-1:0]     i_req_pop,
  input  logic [TREE_NUM*PTW-1:0] i_req_data,
  output logic [TREE_NUM-1:0]     o_req_ready,
  output logic                    o_push,
  output logic                    o_pop,
  output logic [PTW-1:0]          o_push_data,
  output logic [TID-1:0]          o_tree_id,
  input  logic                    i_task_fifo_full,
  input  logic [PTW-1:0]          i_pop_data,
  output logic                    o_rsp_valid,
  output logic [TID-1:0]          o_rsp_tree_id,
  output logic [PTW-1:0]          o_rsp_data,
  output logic [TREE_NUM-1:0]     o_tree_empty,
  output logic [TREE_NUM-1:0]     o_tree_full
);

  // Cooldown counters only need to hold GAP-1.
  localparam int CLW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [CW-1:0]       cnt_q  [TREE_NUM];
  logic [CW-1:0]       cnt_d  [TREE_NUM];
  logic [CLW-1:0]      cool_q [TREE_NUM];
  logic [CLW-1:0]      cool_d [TREE_NUM];
  logic [TID-1:0]      rr_q, rr_d;

  logic                push_q, pop_q;
  logic [PTW-1:0]      push_data_q;
  logic [TID-1:0]      tree_id_q;

  logic [POP_LAT-1:0]  rsp_vld_q;
  logic [TID-1:0]      rsp_id_q [POP_LAT];

  logic [TREE_NUM-1:0] elig;
  logic [TREE_NUM-1:0] grant;
  logic                gnt_vld;
  logic [TID-1:0]      gnt_id;
  logic                gnt_pop;
  logic [PTW-1:0]      gnt_data;
  int                  cand;

  // Per-tree eligibility: valid, not cooling, and the op cannot over/underflow.
  always_comb begin
    elig = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      if (i_req_pop[t]) begin
        elig[t] = i_req_valid[t] && (cool_q[t] == '0) && (cnt_q[t] != '0);
      end else begin
        elig[t] = i_req_valid[t] && (cool_q[t] == '0) &&
                  (cnt_q[t] < CW'(TREE_CAP)) && !i_task_fifo_full;
      end
    end
  end

  // Round-robin pick: first eligible tree at or after rr, wrapping.
  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = 0;
    for (int i = 0; i < TREE_NUM; i++) begin
      cand = (int'(rr_q) + i) % TREE_NUM;
      if (!gnt_vld && elig[cand]) begin
        gnt_vld     = 1'b1;
        gnt_id      = TID'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  assign o_req_ready = grant;
  assign gnt_pop     = i_req_pop[gnt_id];
  assign gnt_data    = i_req_data[gnt_id*PTW +: PTW];

  // Next state of occupancy, cooldown and round-robin pointer.
  always_comb begin
    rr_d = rr_q;
    for (int t = 0; t < TREE_NUM; t++) begin
      cnt_d[t]  = cnt_q[t];
      cool_d[t] = (cool_q[t] != '0) ? cool_q[t] - CLW'(1) : cool_q[t];
    end
    if (gnt_vld) begin
      rr_d           = (gnt_id == TID'(TREE_NUM - 1)) ? '0 : gnt_id + TID'(1);
      cool_d[gnt_id] = CLW'(GAP - 1);
      cnt_d[gnt_id]  = gnt_pop ? cnt_q[gnt_id] - CW'(1) : cnt_q[gnt_id] + CW'(1);
    end
  end

  // Scheduler state and the registered issue interface to the PIFO.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        cnt_q[t]  <= '0;
        cool_q[t] <= '0;
      end
      rr_q        <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_data_q <= '0;
      tree_id_q   <= '0;
    end else begin
      for (int t = 0; t < TREE_NUM; t++) begin
        cnt_q[t]  <= cnt_d[t];
        cool_q[t] <= cool_d[t];
      end
      rr_q   <= rr_d;
      push_q <= gnt_vld && !gnt_pop;
      pop_q  <= gnt_vld && gnt_pop;
      if (gnt_vld) begin
        tree_id_q   <= gnt_id;
        push_data_q <= gnt_pop ? '0 : gnt_data;
      end
    end
  end

  // Pop-response tracker: carries the owning tree id alongside the PIFO latency.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      rsp_vld_q <= '0;
      for (int k = 0; k < POP_LAT; k++) rsp_id_q[k] <= '0;
    end else begin
      rsp_vld_q[0] <= pop_q;
      rsp_id_q[0]  <= tree_id_q;
      for (int k = 1; k < POP_LAT; k++) begin
        rsp_vld_q[k] <= rsp_vld_q[k-1];
        rsp_id_q[k]  <= rsp_id_q[k-1];
      end
    end
  end

  assign o_push        = push_q;
  assign o_pop         = pop_q;
  assign o_push_data   = push_data_q;
  assign o_tree_id     = tree_id_q;
  assign o_rsp_valid   = rsp_vld_q[POP_LAT-1];
  assign o_rsp_tree_id = o_rsp_valid ? rsp_id_q[POP_LAT-1] : '0;
  assign o_rsp_data    = o_rsp_valid ? i_pop_data : '0;

  // Occupancy flags decoded from the registered counters.
  always_comb begin
    o_tree_empty = '0;
    o_tree_full  = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      o_tree_empty[t] = (cnt_q[t] == '0);
      o_tree_full[t]  = (cnt_q[t] == CW'(TREE_CAP));
    end
  end

endmodule

// File: tb/tb_vpifo_op_scheduler.sv
// Directed testbench for vpifo_op_scheduler (default parameters, GAP=2).
module tb_vpifo_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_pop;
  logic [63:0] req_data;
  logic [3:0]  ready;
  logic        push, pop;
  logic [15:0] push_data;
  logic [1:0]  tree_id;
  logic        fifo_full;
  logic [15:0] pop_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic [3:0]  empty, full;

  int checks   = 0;
  int failures = 0;

  vpifo_op_scheduler dut (
    .i_clk            (clk),
    .i_arst_n         (rst_n),
    .i_req_valid      (req_valid),
    .i_req_pop        (req_pop),
    .i_req_data       (req_data),
    .o_req_ready      (ready),
    .o_push           (push),
    .o_pop            (pop),
    .o_push_data      (push_data),
    .o_tree_id        (tree_id),
    .i_task_fifo_full (fifo_full),
    .i_pop_data       (pop_data),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_tree_id    (rsp_id),
    .o_rsp_data       (rsp_data),
    .o_tree_empty     (empty),
    .o_tree_full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_pop = '0; req_data = '0; fifo_full = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Single-tree request, waits (bounded) for ready, checks the issued strobe.
  task automatic issue(input int t, input logic pop_op, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = '0; req_pop = '0;
    req_valid[t] = 1'b1;
    req_pop[t]   = pop_op;
    req_data[t*16 +: 16] = d;
    #1;
    while (ready[t] !== 1'b1 && n < 20) begin
      step(); #1; n++;
    end
    chk("issue_rdy", ready[t], 1);
    step();
    chk("issue_op", {push, pop}, pop_op ? 2'b01 : 2'b10);
    chk("issue_id", tree_id, t);
    req_valid = '0;
  endtask

  initial begin
    pop_data = 16'h1005;
    do_reset();
    step();

    // Reset / idle state
    chk("rst_push", push, 0);
    chk("rst_pop", pop, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_empty", empty, 4'hf);
    chk("rst_full", full, 0);
    chk("rst_ready", ready, 0);

    // All trees push continuously: grants rotate 0,1,2,3,...
    req_valid = 4'hf; req_pop = 4'h0;
    for (int t = 0; t < 4; t++) req_data[t*16 +: 16] = 16'h0100 + 16'(t);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rot_ready", ready, 4'b0001 << (k % 4));
      step();
      chk("rot_push", push, 1);
      chk("rot_id", tree_id, k % 4);
      chk("rot_data", push_data, 16'h0100 + 16'(k % 4));
    end
    req_valid = '0;
    step();
    chk("rot_empty", empty, 4'h0);

    // Tree 0 fills to capacity; cooldown gives a grant every other cycle
    do_reset();
    req_valid = 4'b0001; req_pop = 4'b0000;
    for (int n = 0; n < 72; n++) begin
      req_data[15:0] = 16'(n);
      #1;
      chk("fill_ready", ready, 4'b0001);
      step();
      chk("fill_push", push, 1);
      chk("fill_data", push_data, 16'(n));
      #1;
      chk("fill_cool", ready, 4'b0000);
      step();
      chk("fill_idle", push, 0);
    end
    chk("fill_full", full, 4'b0001);
    chk("fill_notempty", empty, 4'b1110);
    #1;
    chk("full_hold", ready, 4'b0000);
    step();
    chk("full_nopush", push, 0);
    req_pop = 4'b0001;
    #1;
    chk("full_pop_rdy", ready, 4'b0001);
    step();
    chk("full_pop", {push, pop}, 2'b01);
    chk("full_cleared", full, 4'b0000);
    req_valid = '0; req_pop = '0;

    // Tree 1: pop while empty is held, then push, pop and response routing
    do_reset();
    req_valid = 4'b0010; req_pop = 4'b0010;
    #1;
    chk("emp_pop_rdy", ready, 0);
    step();
    chk("emp_no_pop", pop, 0);
    step();
    chk("emp_no_pop2", pop, 0);
    req_pop = 4'b0000; req_data[31:16] = 16'h1005;
    #1;
    chk("t1_push_rdy", ready, 4'b0010);
    step();
    chk("t1_push", push, 1);
    chk("t1_push_id", tree_id, 1);
    chk("t1_push_data", push_data, 16'h1005);
    chk("t1_notempty", empty, 4'b1101);
    req_pop = 4'b0010;
    #1;
    chk("t1_cool", ready, 0);
    step();
    #1;
    chk("t1_pop_rdy", ready, 4'b0010);
    step();
    chk("t1_pop", {push, pop}, 2'b01);
    chk("t1_pop_id", tree_id, 1);
    chk("t1_pop_data0", push_data, 0);
    req_valid = '0; req_pop = '0;
    step();
    chk("rsp_lat1", rsp_valid, 0);
    chk("t1_empty", empty, 4'hf);
    step();
    chk("rsp_lat2", rsp_valid, 0);
    step();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, 1);
    chk("rsp_data", rsp_data, 16'h1005);
    step();
    chk("rsp_off", rsp_valid, 0);
    chk("rsp_data0", rsp_data, 0);

    // FIFO full blocks pushes but not pops
    do_reset();
    for (int n = 0; n < 5; n++) issue(3, 1'b0, 16'h3000 + 16'(n));
    step();
    fifo_full = 1'b1;
    req_valid = 4'b1100; req_pop = 4'b1000; req_data[47:32] = 16'h2222;
    #1;
    chk("ff_ready", ready, 4'b1000);
    step();
    chk("ff_pop", {push, pop}, 2'b01);
    chk("ff_pop_id", tree_id, 3);
    #1;
    chk("ff_block", ready, 0);
    step();
    chk("ff_idle", {push, pop}, 2'b00);
    fifo_full = 1'b0; req_valid = 4'b0100;
    #1;
    chk("ff_release", ready, 4'b0100);
    step();
    chk("ff_push", push, 1);
    chk("ff_push_id", tree_id, 2);
    chk("ff_push_data", push_data, 16'h2222);
    req_valid = '0; req_pop = '0;

    // Reset with two pops in flight
    do_reset();
    for (int n = 0; n < 10; n++) issue(0, 1'b0, 16'(n));
    issue(0, 1'b1, 16'h0);
    issue(0, 1'b1, 16'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rr_rst_empty", empty, 4'hf);
    chk("rr_rst_strobe", {push, pop}, 2'b00);
    for (int k = 0; k < 5; k++) begin
      chk("rr_rst_rsp", rsp_valid, 0);
      step();
    end
    req_valid = 4'hf; req_pop = 4'h0;
    #1;
    chk("rr_restart", ready, 4'b0001);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
